// File: rtl/hs_merge_pool_pkg.sv
// Shared flit field layout and master-buffer state encoding for the hot-spot merge pool.
package hs_merge_pool_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int IR_WIDTH   = 8;

    // Flit layout: [0] hs, [4:1] dst, [12:5] src list, [28:13] mem addr, upper bits payload
    localparam int HS_POS       = 0;
    localparam int DST_POS      = 1;
    localparam int DST_W        = 4;
    localparam int SRC_LIST_POS = 5;
    localparam int SRC_LIST_W   = 8;
    localparam int MEM_ADDR_POS = 13;
    localparam int MEM_ADDR_W   = 16;
    localparam int KEY_W        = MEM_ADDR_W + DST_W;

    typedef enum logic [1:0] {
        MB_EMPTY = 2'd0,
        MB_ACCUM = 2'd1,
        MB_PEND  = 2'd2
    } mbuf_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hs_mbuf_entry.sv
// One master buffer: state FSM, age and fan-in counters, stored flit and per-port key comparator.
module hs_mbuf_entry
    import hs_merge_pool_pkg::*;
#(
    parameter int NUM_PORT  = 5,
    parameter int DATA_W    = DATA_WIDTH,
    parameter int IR_W      = IR_WIDTH,
    parameter int TIMEOUT   = 16,
    parameter int MAX_FANIN = 4,
    localparam int FW = IR_W + DATA_W,
    localparam int CW = $clog2(NUM_PORT + 1),
    localparam int AW = $clog2(TIMEOUT + 1),
    localparam int NW = $clog2(MAX_FANIN + 1)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_PORT-1:0]       port_hs,
    input  logic [NUM_PORT*KEY_W-1:0] port_key,
    output logic [NUM_PORT-1:0]       match,
    input  logic                      alloc,
    input  logic [FW-1:0]             alloc_flit,
    input  logic [CW-1:0]             add_cnt,
    input  logic [SRC_LIST_W-1:0]     add_src,
    input  logic                      flush_take,
    output mbuf_state_e               state,
    output mbuf_state_e               state_nxt,
    output logic [FW-1:0]             flit_nxt
);

    localparam logic [AW-1:0] AGE_LAST = AW'(TIMEOUT - 1);

    logic [FW-1:0]    flit;
    logic [AW-1:0]    age, age_nxt;
    logic [NW-1:0]    fanin, fanin_nxt;
    logic [31:0]      sum;
    logic [KEY_W-1:0] key;

    assign key = {flit[MEM_ADDR_POS +: MEM_ADDR_W], flit[DST_POS +: DST_W]};

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            match[p] = (state == MB_ACCUM) && port_hs[p] && (port_key[p*KEY_W +: KEY_W] == key);
        end
    end

    always_comb begin
        state_nxt = state;
        flit_nxt  = flit;
        fanin_nxt = fanin;
        age_nxt   = age;
        sum       = '0;
        case (state)
            MB_EMPTY: begin
                if (alloc) begin
                    // Same-cycle coalesced ports ride in on add_cnt/add_src
                    flit_nxt = alloc_flit;
                    flit_nxt[SRC_LIST_POS +: SRC_LIST_W] = alloc_flit[SRC_LIST_POS +: SRC_LIST_W] | add_src;
                    sum       = 32'(add_cnt) + 32'd1;
                    fanin_nxt = (sum >= 32'(MAX_FANIN)) ? NW'(MAX_FANIN) : NW'(sum);
                    age_nxt   = '0;
                    state_nxt = MB_ACCUM;
                end
            end
            MB_ACCUM: begin
                flit_nxt[SRC_LIST_POS +: SRC_LIST_W] = flit[SRC_LIST_POS +: SRC_LIST_W] | add_src;
                sum       = 32'(fanin) + 32'(add_cnt);
                fanin_nxt = (sum >= 32'(MAX_FANIN)) ? NW'(MAX_FANIN) : NW'(sum);
                if ((age == AGE_LAST) || (sum >= 32'(MAX_FANIN))) begin
                    state_nxt = MB_PEND;
                end else begin
                    age_nxt = age + AW'(1);
                end
            end
            MB_PEND: begin
                if (flush_take) state_nxt = MB_EMPTY;
            end
            default: state_nxt = MB_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= MB_EMPTY;
            flit  <= '0;
            age   <= '0;
            fanin <= '0;
        end else begin
            state <= state_nxt;
            flit  <= flit_nxt;
            age   <= age_nxt;
            fanin <= fanin_nxt;
        end
    end

endmodule

// File: rtl/hs_merge_pool.sv
// Hot-spot flit merge stage: port-order allocator with intra-cycle coalescing, entry pool, flush arbiter.
module hs_merge_pool
    import hs_merge_pool_pkg::*;
#(
    parameter int NUM_PORT  = 5,
    parameter int NUM_MBUF  = 5,
    parameter int DATA_W    = DATA_WIDTH,
    parameter int IR_W      = IR_WIDTH,
    parameter int TIMEOUT   = 16,
    parameter int MAX_FANIN = 4,
    localparam int FW = IR_W + DATA_W
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_PORT*DATA_W-1:0] data_in,
    input  logic [NUM_PORT*IR_W-1:0]   pre_route,
    output logic [NUM_PORT*FW-1:0]     data_out,
    output logic [NUM_PORT-1:0]        merged,
    output logic [NUM_MBUF-1:0]        mbuf_empty,
    output logic                       flush_valid,
    output logic [FW-1:0]              flush_data,
    input  logic                       flush_ready,
    output logic [2*NUM_MBUF-1:0]      mbuf_state
);

    localparam int CW = $clog2(NUM_PORT + 1);
    localparam int IW = idx_w(NUM_MBUF);

    logic [NUM_PORT-1:0]       port_hs;
    logic [NUM_PORT*KEY_W-1:0] port_key;
    logic [SRC_LIST_W-1:0]     port_src [NUM_PORT];

    logic [NUM_PORT-1:0]   ent_match [NUM_MBUF];
    logic [NUM_PORT-1:0]   add_vec   [NUM_MBUF];
    logic [FW-1:0]         alloc_flit[NUM_MBUF];
    logic [CW-1:0]         add_cnt   [NUM_MBUF];
    logic [SRC_LIST_W-1:0] add_src   [NUM_MBUF];
    logic [FW-1:0]         ent_flit_nxt [NUM_MBUF];
    mbuf_state_e           ent_state     [NUM_MBUF];
    mbuf_state_e           ent_state_nxt [NUM_MBUF];
    logic [NUM_MBUF-1:0]   alloc_e, taken, flush_take;
    logic [NUM_PORT-1:0]   merged_c, alloc_by;
    logic [IW-1:0]         alloc_ent [NUM_PORT];
    logic                  done;

    logic                  pick_vld;
    logic [IW-1:0]         pick_idx;
    logic [FW-1:0]         pick_data;
    logic [IW-1:0]         flush_sel;

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            port_hs[p]                  = data_in[p*DATA_W + HS_POS];
            port_key[p*KEY_W +: KEY_W]  = {data_in[p*DATA_W + MEM_ADDR_POS +: MEM_ADDR_W],
                                           data_in[p*DATA_W + DST_POS +: DST_W]};
            port_src[p]                 = data_in[p*DATA_W + SRC_LIST_POS +: SRC_LIST_W];
        end
    end

    // Ports are resolved in ascending order: existing ACCUM match, then an entry opened earlier
    // this cycle with the same key, then the lowest free entry; otherwise the flit passes through.
    always_comb begin
        taken    = '0;
        alloc_e  = '0;
        merged_c = '0;
        alloc_by = '0;
        done     = 1'b0;
        for (int e = 0; e < NUM_MBUF; e++) begin
            add_vec[e]    = '0;
            alloc_flit[e] = '0;
        end
        for (int p = 0; p < NUM_PORT; p++) alloc_ent[p] = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            done = 1'b0;
            if (port_hs[p]) begin
                for (int e = 0; e < NUM_MBUF; e++) begin
                    if (!done && ent_match[e][p]) begin
                        add_vec[e][p] = 1'b1;
                        done = 1'b1;
                    end
                end
                for (int q = 0; q < p; q++) begin
                    if (!done && alloc_by[q] &&
                        (port_key[q*KEY_W +: KEY_W] == port_key[p*KEY_W +: KEY_W])) begin
                        for (int e = 0; e < NUM_MBUF; e++) begin
                            if (alloc_ent[q] == IW'(e)) add_vec[e][p] = 1'b1;
                        end
                        done = 1'b1;
                    end
                end
                for (int e = 0; e < NUM_MBUF; e++) begin
                    if (!done && (ent_state[e] == MB_EMPTY) && !taken[e]) begin
                        taken[e]      = 1'b1;
                        alloc_e[e]    = 1'b1;
                        alloc_by[p]   = 1'b1;
                        alloc_ent[p]  = IW'(e);
                        alloc_flit[e] = {pre_route[p*IR_W +: IR_W], data_in[p*DATA_W +: DATA_W]};
                        done = 1'b1;
                    end
                end
            end
            merged_c[p] = done;
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_MBUF; e++) begin
            add_cnt[e] = '0;
            add_src[e] = '0;
            for (int p = 0; p < NUM_PORT; p++) begin
                if (add_vec[e][p]) begin
                    add_cnt[e] = add_cnt[e] + CW'(1);
                    add_src[e] = add_src[e] | port_src[p];
                end
            end
        end
    end

    for (genvar e = 0; e < NUM_MBUF; e++) begin : g_ent
        hs_mbuf_entry #(
            .NUM_PORT (NUM_PORT),
            .DATA_W   (DATA_W),
            .IR_W     (IR_W),
            .TIMEOUT  (TIMEOUT),
            .MAX_FANIN(MAX_FANIN)
        ) u_ent (
            .clk       (clk),
            .n_rst     (n_rst),
            .port_hs   (port_hs),
            .port_key  (port_key),
            .match     (ent_match[e]),
            .alloc     (alloc_e[e]),
            .alloc_flit(alloc_flit[e]),
            .add_cnt   (add_cnt[e]),
            .add_src   (add_src[e]),
            .flush_take(flush_take[e]),
            .state     (ent_state[e]),
            .state_nxt (ent_state_nxt[e]),
            .flit_nxt  (ent_flit_nxt[e])
        );
        assign mbuf_empty[e]         = (ent_state[e] == MB_EMPTY);
        assign mbuf_state[2*e +: 2]  = ent_state[e];
        assign flush_take[e]         = flush_valid && flush_ready && (flush_sel == IW'(e));
    end

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_out
        assign data_out[p*FW +: FW] = merged[p] ? '0
                                    : {pre_route[p*IR_W +: IR_W], data_in[p*DATA_W +: DATA_W]};
    end

    assign merged = n_rst ? merged_c : '0;

    // Lowest entry that will be PEND after this edge; an entry being flushed now goes EMPTY.
    always_comb begin
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pick_data = '0;
        for (int e = NUM_MBUF - 1; e >= 0; e--) begin
            if (ent_state_nxt[e] == MB_PEND) begin
                pick_vld  = 1'b1;
                pick_idx  = IW'(e);
                pick_data = ent_flit_nxt[e];
            end
        end
    end

    // Flush handshake: a transfer happens on a clk edge where flush_valid && flush_ready; while
    // flush_valid is high and flush_ready low, flush_valid and flush_data hold unchanged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flush_valid <= 1'b0;
            flush_sel   <= '0;
            flush_data  <= '0;
        end else if (!flush_valid || flush_ready) begin
            flush_valid <= pick_vld;
            flush_sel   <= pick_idx;
            flush_data  <= pick_data;
        end
    end

endmodule
